rx_word_align: RTL and testbench
================================

Name: rx_word_align

Overview:
- Receive-side word aligner for the 10-bit DDR serial link: the counterpart of the transmit serializer.
- Takes raw 10-bit words from the receive ISERDES on pixel_clk. The word boundary is arbitrary.
- Locates the boundary by hunting for a training pattern and applies the transmitter's bit order (bitswap).
- Delivers aligned 10-bit words with lock status to downstream decode logic.

Parameters:
- TRAIN_PATTERN, 10'b1111100000: training word as presented on the transmitter's data[9:0]. All 10 rotations must be distinct.
- LOCK_COUNT, 16: consecutive matches at one offset required to declare lock. Range 1..255.
- ERR_LIMIT, 4: consecutive mismatches while locked and train=1 that drop lock. Range 1..255.
- MAX_SWEEPS, 8: full 10-offset sweeps without any match before align_fail pulses. Range 1..255.

Ports:
- pixel_clk  input  1  word clock; all logic on rising edge
- reset_int  input  1  asynchronous, active-high reset
- rx_word  input  10  raw ISERDES word; bit 0 = earliest received bit
- bitswap  input  1  0: first serial bit is data[0]; 1: first serial bit is data[9]. Quasi-static.
- train  input  1  link partner is sending TRAIN_PATTERN
- realign  input  1  single-cycle request to restart the search
- data_out  output  10  aligned word, transmitter's data[9:0] order
- data_valid  output  1  data_out is aligned (state LOCKED)
- locked  output  1  lock status
- offset  output  4  current bit offset, 0..9
- align_fail  output  1  one-cycle pulse, search exhausted

Behaviour:
- Reset (async assert; deassert synchronised externally):
  - data_out=0, data_valid=0, locked=0, offset=0, align_fail=0.
  - hist=0, state=SEARCH, all counters 0.
- History register: hist[19:0] <= {rx_word, hist[19:10]} every cycle.
- Candidate: cand = hist[offset+9 : offset]. If bitswap=1, the candidate is bit-reversed (cand[i] -> cand[9-i]).
- match = (candidate after reversal == TRAIN_PATTERN).
- Output path: data_out <= candidate after reversal, every cycle in every state.
- Latency: rx_word to data_out is 2 pixel_clk cycles at offset 0.
- data_valid = locked = (state==LOCKED), registered.
- State SEARCH:
  - match -> CHECK, match_cnt=1. If LOCK_COUNT==1, go directly to LOCKED.
  - no match -> offset increments, wrapping 9->0.
  - On each 9->0 wrap, sweep_cnt increments.
  - When sweep_cnt reaches MAX_SWEEPS: align_fail pulses for 1 cycle, sweep_cnt clears, search continues.
- State CHECK:
  - match -> match_cnt increments. When match_cnt reaches LOCK_COUNT -> LOCKED, sweep_cnt clears.
  - mismatch -> SEARCH, offset increments (with wrap), match_cnt clears.
- State LOCKED:
  - Offset frozen.
  - If train=1 and mismatch: err_cnt increments. When err_cnt reaches ERR_LIMIT -> SEARCH with offset unchanged, err_cnt clears.
  - If train=1 and match: err_cnt clears.
  - If train=0: err_cnt holds; no checking.
- realign:
  - Any state -> SEARCH next cycle; match_cnt and err_cnt clear, offset held.
  - Takes priority over all other transitions in the same cycle.
- locked falls in the cycle after the transition to SEARCH.
- Counters saturate; none wraps past its limit.
- bitswap change while LOCKED: no automatic action; the system must issue realign.

Optional Feature:
- Macro RX_ALIGN_STATS_EN.
- Defined: adds two outputs.
  - lock_loss_cnt[15:0] increments on each LOCKED->SEARCH transition, from realign or ERR_LIMIT; saturates at 16'hFFFF.
  - slip_total[15:0] increments on each offset advance; saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Feed serializer-model stream of 10'h3E0, bitswap=0, skewed 3 bits, train=1 -> offset settles at 3; locked=1 after the 16th consecutive match; data_out=10'h3E0 thereafter.
- Same stream, bitswap=1 both ends, skew 7 -> locked=1 at offset 7; after lock, payload 10'h155 reappears as data_out=10'h155 two cycles after its word.
- Locked, train=1, inject 4 consecutive corrupted words -> locked=0 the cycle after the 4th. Inject 3 corrupted then a good word -> locked stays 1.
- Constant rx_word=10'h000 -> align_fail pulses once every 80 cycles (8 sweeps x 10 offsets); locked stays 0.
- Locked, pulse realign together with a mismatch -> state SEARCH, offset unchanged; relocks at the same offset after 16 matches.
- Assert reset_int mid-CHECK -> all outputs 0 immediately without a clock edge; after release, search restarts at offset 0.

Source files
------------

// File: rtl/rx_word_align_if.sv
// rx_word_align_if: raw-word input, alignment controls and aligned-word/status outputs.
// RX_ALIGN_STATS_EN adds the lock_loss_cnt and slip_total statistics outputs.
interface rx_word_align_if;
  logic [9:0]  rx_word;
  logic        bitswap;
  logic        train;
  logic        realign;
  logic [9:0]  data_out;
  logic        data_valid;
  logic        locked;
  logic [3:0]  offset;
  logic        align_fail;
`ifdef RX_ALIGN_STATS_EN
  logic [15:0] lock_loss_cnt;
  logic [15:0] slip_total;

  modport master (
    output rx_word, bitswap, train, realign,
    input  data_out, data_valid, locked, offset, align_fail, lock_loss_cnt, slip_total
  );
  modport slave (
    input  rx_word, bitswap, train, realign,
    output data_out, data_valid, locked, offset, align_fail, lock_loss_cnt, slip_total
  );
`else
  modport master (
    output rx_word, bitswap, train, realign,
    input  data_out, data_valid, locked, offset, align_fail
  );
  modport slave (
    input  rx_word, bitswap, train, realign,
    output data_out, data_valid, locked, offset, align_fail
  );
`endif
endinterface

// File: rtl/rx_word_align.sv
// rx_word_align: hunts for the training word across all 10 bit offsets and delivers aligned words.
// Optional RX_ALIGN_STATS_EN adds lock-loss and offset-slip counters.
module rx_word_align #(
  parameter logic [9:0]  TRAIN_PATTERN = 10'b1111100000,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned ERR_LIMIT     = 4,
  parameter int unsigned MAX_SWEEPS    = 8
) (
  input logic           pixel_clk,
  input logic           reset_int,
  rx_word_align_if.slave link
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  localparam logic [7:0] LOCK_LAST  = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] LOCK_SAT   = 8'(LOCK_COUNT);
  localparam logic [7:0] ERR_LAST   = 8'(ERR_LIMIT - 1);
  localparam logic [7:0] SWEEP_LAST = 8'(MAX_SWEEPS - 1);

  state_t      state, state_nxt;
  logic [19:0] hist;
  logic [3:0]  offset, offset_nxt;
  logic [7:0]  match_cnt, match_cnt_nxt;
  logic [7:0]  err_cnt, err_cnt_nxt;
  logic [7:0]  sweep_cnt, sweep_cnt_nxt;
  logic        fail_nxt, advance;
  logic [9:0]  data_q;
  logic        locked_q, fail_q;

  logic [19:0] window;
  logic [9:0]  cand_raw, cand_rev, cand;
  logic        match, locked_nxt;

  always_ff @(posedge pixel_clk or posedge reset_int) begin
    if (reset_int) begin
      state     <= SEARCH;
      hist      <= '0;
      offset    <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
      sweep_cnt <= '0;
      data_q    <= '0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hist      <= {link.rx_word, hist[19:10]};
      offset    <= offset_nxt;
      match_cnt <= match_cnt_nxt;
      err_cnt   <= err_cnt_nxt;
      sweep_cnt <= sweep_cnt_nxt;
      data_q    <= cand;
      locked_q  <= locked_nxt;
      fail_q    <= fail_nxt;
    end
  end

  // realign overrides every state transition; the offset is kept so relock can happen in place
  always_comb begin
    state_nxt     = state;
    offset_nxt    = offset;
    match_cnt_nxt = match_cnt;
    err_cnt_nxt   = err_cnt;
    sweep_cnt_nxt = sweep_cnt;
    fail_nxt      = 1'b0;
    advance       = 1'b0;
    if (link.realign) begin
      state_nxt     = SEARCH;
      match_cnt_nxt = '0;
      err_cnt_nxt   = '0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (match) begin
            match_cnt_nxt = 8'd1;
            if (LOCK_COUNT == 1) begin
              state_nxt     = LOCKED;
              sweep_cnt_nxt = '0;
            end else begin
              state_nxt = CHECK;
            end
          end else begin
            advance = 1'b1;
            if (offset == 4'd9) begin
              if (sweep_cnt >= SWEEP_LAST) begin
                fail_nxt      = 1'b1;
                sweep_cnt_nxt = '0;
              end else begin
                sweep_cnt_nxt = sweep_cnt + 8'd1;
              end
            end
          end
        end
        CHECK: begin
          if (match) begin
            if (match_cnt >= LOCK_LAST) begin
              state_nxt     = LOCKED;
              sweep_cnt_nxt = '0;
              match_cnt_nxt = LOCK_SAT;
            end else begin
              match_cnt_nxt = match_cnt + 8'd1;
            end
          end else begin
            state_nxt     = SEARCH;
            match_cnt_nxt = '0;
            advance       = 1'b1;
          end
        end
        LOCKED: begin
          if (link.train) begin
            if (match) begin
              err_cnt_nxt = '0;
            end else if (err_cnt >= ERR_LAST) begin
              state_nxt   = SEARCH;
              err_cnt_nxt = '0;
            end else begin
              err_cnt_nxt = err_cnt + 8'd1;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
    if (advance) offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  end

  always_comb begin
    window   = hist >> offset;
    cand_raw = window[9:0];
    cand_rev = '0;
    for (int unsigned i = 0; i < 10; i++) cand_rev[i] = cand_raw[9 - i];
    cand       = link.bitswap ? cand_rev : cand_raw;
    match      = (cand == TRAIN_PATTERN);
    locked_nxt = (state_nxt == LOCKED);
  end

  assign link.data_out   = data_q;
  assign link.data_valid = locked_q;
  assign link.locked     = locked_q;
  assign link.offset     = offset;
  assign link.align_fail = fail_q;

`ifdef RX_ALIGN_STATS_EN
  logic [15:0] lock_loss_q, slip_q;

  always_ff @(posedge pixel_clk or posedge reset_int) begin
    if (reset_int) begin
      lock_loss_q <= '0;
      slip_q      <= '0;
    end else begin
      if (state == LOCKED && state_nxt == SEARCH && lock_loss_q != '1) lock_loss_q <= lock_loss_q + 16'd1;
      if (advance && slip_q != '1) slip_q <= slip_q + 16'd1;
    end
  end

  assign link.lock_loss_cnt = lock_loss_q;
  assign link.slip_total    = slip_q;
`endif

endmodule

// File: tb/tb_rx_word_align.sv
// tb_rx_word_align: drives a serializer-model bit stream into rx_word_align and checks it
// against a serial-window reference model plus fixed expectations for lock, loss and failure.
module tb_rx_word_align;
  localparam logic [9:0] PAT    = 10'h3E0;
  localparam int         LOCK_N = 16;
  localparam int         ERR_N  = 4;
  localparam int         SWP_N  = 8;

  logic pixel_clk = 1'b0;
  logic reset_int = 1'b1;

  rx_word_align_if link ();

  rx_word_align #(
    .TRAIN_PATTERN(PAT),
    .LOCK_COUNT(LOCK_N),
    .ERR_LIMIT(ERR_N),
    .MAX_SWEEPS(SWP_N)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset_int(reset_int),
    .link(link.slave)
  );

  always #5 pixel_clk = ~pixel_clk;

  int total = 0;
  int bad   = 0;

  bit ser_q[$];
  bit tx_swap;

  // model: the two most recent raw words form a 20-bit serial window, read at m_off
  logic [9:0]  m_old, m_new, m_data, m_c;
  logic [16:0] exp_v, got_v;
  int          m_off, m_phase, m_run, m_err, m_sweeps, m_loss, m_slips;
  bit          m_fail, m_hit;

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  task automatic model_reset();
    m_old = '0; m_new = '0; m_data = '0; m_off = 0; m_phase = 0;
    m_run = 0; m_err = 0; m_sweeps = 0; m_fail = 0; m_loss = 0; m_slips = 0;
  endtask

  task automatic model_step();
    m_c = 10'(({m_new, m_old}) >> m_off);
    if (link.bitswap) m_c = rev10(m_c);
    m_hit  = (m_c == PAT);
    m_data = m_c;
    m_old  = m_new;
    m_new  = link.rx_word;
    m_fail = 0;
    if (link.realign) begin
      if (m_phase == 2) m_loss++;
      m_phase = 0; m_run = 0; m_err = 0;
    end else if (m_phase == 0) begin
      if (m_hit) begin
        m_run = 1;
        if (LOCK_N == 1) begin m_phase = 2; m_sweeps = 0; end
        else m_phase = 1;
      end else begin
        m_off++; m_slips++;
        if (m_off == 10) begin
          m_off = 0; m_sweeps++;
          if (m_sweeps == SWP_N) begin m_fail = 1; m_sweeps = 0; end
        end
      end
    end else if (m_phase == 1) begin
      if (m_hit) begin
        m_run++;
        if (m_run >= LOCK_N) begin m_phase = 2; m_sweeps = 0; end
      end else begin
        m_phase = 0; m_run = 0; m_off = (m_off + 1) % 10; m_slips++;
      end
    end else if (link.train) begin
      if (m_hit) m_err = 0;
      else begin
        m_err++;
        if (m_err >= ERR_N) begin m_phase = 0; m_err = 0; m_loss++; end
      end
    end
    exp_v = {m_data, m_phase == 2, m_phase == 2, 4'(m_off), m_fail};
  endtask

  task automatic start_link(input int skew, input bit swap);
    tx_swap = swap;
    link.bitswap = swap;
    ser_q.delete();
    for (int i = 0; i < skew; i++) ser_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic step_raw(input logic [9:0] rx);
    link.rx_word = rx;
    model_step();
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    got_v = {link.data_out, link.data_valid, link.locked, link.offset, link.align_fail};
  endtask

  task automatic step(input logic [9:0] w);
    logic [9:0] rx;
    for (int i = 0; i < 10; i++) ser_q.push_back(tx_swap ? w[9-i] : w[i]);
    for (int i = 0; i < 10; i++) rx[i] = ser_q.pop_front();
    step_raw(rx);
  endtask

  function automatic logic [9:0] corrupt_word();
    logic [9:0] w;
    w = 10'($urandom);
    if (w == PAT) w = ~w;
    return w;
  endfunction

  task automatic test_reset();
    link.rx_word = '0; link.bitswap = 0; link.train = 0; link.realign = 0;
    reset_int = 1'b1;
    model_reset();
    repeat (3) @(negedge pixel_clk);
    total++; if (link.data_out !== 10'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", link.data_out); end
    total++; if (link.data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", link.data_valid); end
    total++; if (link.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", link.locked); end
    total++; if (link.offset !== 4'd0) begin bad++; $display("FAIL reset_offset got=%0d exp=0", link.offset); end
    total++; if (link.align_fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b exp=0", link.align_fail); end
    reset_int = 1'b0;
  endtask

  task automatic lock_up(input string name, input int want_off);
    int n;
    n = 0;
    while (!link.locked && n < 80) begin
      step(PAT); n++;
      total++; if (got_v !== exp_v) begin bad++; $display("FAIL %s_cycle n=%0d got=%h exp=%h", name, n, got_v, exp_v); end
    end
    total++; if (link.locked !== 1'b1) begin bad++; $display("FAIL %s_lock_timeout got=%b exp=1", name, link.locked); end
    total++; if (link.offset !== 4'(want_off)) begin bad++; $display("FAIL %s_offset got=%0d exp=%0d", name, link.offset, want_off); end
  endtask

  task automatic test_lock_plain();
    link.train = 1;
    start_link(3, 0);
    lock_up("plain", 3);
    repeat (5) begin
      step(PAT);
      total++; if (link.data_out !== 10'h3E0 || link.locked !== 1'b1) begin
        bad++; $display("FAIL plain_data got=%h/%b exp=3e0/1", link.data_out, link.locked);
      end
    end
  endtask

  task automatic test_bitswap();
    start_link(7, 1);
    link.realign = 1; step(PAT); link.realign = 0;
    total++; if (link.locked !== 1'b0) begin bad++; $display("FAIL swap_unlock got=%b exp=0", link.locked); end
    lock_up("swap", 7);
    link.train = 0;
    step(10'h155); step(PAT); step(PAT);
    total++; if (link.data_out !== 10'h155) begin bad++; $display("FAIL swap_payload got=%h exp=155", link.data_out); end
    link.train = 1;
    repeat (3) step(PAT);
  endtask

  task automatic test_payload_random();
    logic [9:0] sent[$];
    logic [9:0] w;
    link.train = 0;
    for (int i = 0; i < 12; i++) begin
      w = 10'($urandom);
      sent.push_back(w);
      step(w);
      if (i >= 2) begin
        total++; if (link.data_out !== sent[i-2]) begin bad++; $display("FAIL payload_lag i=%0d got=%h exp=%h", i, link.data_out, sent[i-2]); end
        total++; if (got_v !== exp_v) begin bad++; $display("FAIL payload_cycle i=%0d got=%h exp=%h", i, got_v, exp_v); end
      end
    end
    link.train = 1;
    repeat (3) step(PAT);
  endtask

  task automatic test_err_limit();
    repeat (3) step(corrupt_word());
    repeat (5) begin
      step(PAT);
      total++; if (link.locked !== 1'b1 || got_v !== exp_v) begin bad++; $display("FAIL err3_hold got=%h exp=%h", got_v, exp_v); end
    end
    repeat (4) step(corrupt_word());
    step(PAT);
    total++; if (link.locked !== 1'b1) begin bad++; $display("FAIL err4_before got=%b exp=1", link.locked); end
    step(PAT);
    total++; if (link.locked !== 1'b0) begin bad++; $display("FAIL err4_drop got=%b exp=0", link.locked); end
    total++; if (link.offset !== 4'd7) begin bad++; $display("FAIL err4_offset got=%0d exp=7", link.offset); end
    lock_up("err_relock", 7);
  endtask

  task automatic test_realign();
    int n;
    step(corrupt_word());
    step(PAT);
    link.realign = 1; step(PAT); link.realign = 0;
    total++; if (link.locked !== 1'b0 || link.offset !== 4'd7) begin
      bad++; $display("FAIL realign_drop got=%b/%0d exp=0/7", link.locked, link.offset);
    end
    n = 0;
    while (!link.locked && n < 40) begin
      step(PAT); n++;
      total++; if (got_v !== exp_v) begin bad++; $display("FAIL realign_cycle n=%0d got=%h exp=%h", n, got_v, exp_v); end
    end
    total++; if (n !== LOCK_N) begin bad++; $display("FAIL realign_relock_cycles got=%0d exp=%0d", n, LOCK_N); end
    total++; if (link.offset !== 4'd7) begin bad++; $display("FAIL realign_offset got=%0d exp=7", link.offset); end
  endtask

  task automatic test_align_fail();
    int pulses[$];
    int ever_locked;
    test_reset();
    ever_locked = 0;
    for (int c = 1; c <= 250; c++) begin
      step_raw(10'h000);
      if (link.align_fail) pulses.push_back(c);
      if (link.locked) ever_locked++;
      total++; if (got_v !== exp_v) begin bad++; $display("FAIL fail_cycle c=%0d got=%h exp=%h", c, got_v, exp_v); end
    end
    total++; if (pulses.size() !== 3) begin bad++; $display("FAIL fail_count got=%0d exp=3", pulses.size()); end
    for (int i = 1; i < pulses.size(); i++) begin
      total++; if (pulses[i] - pulses[i-1] !== 80) begin bad++; $display("FAIL fail_period got=%0d exp=80", pulses[i] - pulses[i-1]); end
    end
    total++; if (ever_locked !== 0) begin bad++; $display("FAIL fail_locked got=%0d exp=0", ever_locked); end
  endtask

  task automatic test_reset_mid_check();
    int skew, n;
    skew = $urandom_range(3, 9);
    link.train = 1;
    start_link(skew, 0);
    n = 0;
    while (!(m_phase == 1 && m_run >= 5) && n < 60) begin step(PAT); n++; end
    total++; if (link.offset !== 4'(skew)) begin bad++; $display("FAIL midchk_offset got=%0d exp=%0d", link.offset, skew); end
    #2 reset_int = 1'b1;
    #1;
    total++; if ({link.data_out, link.data_valid, link.locked, link.offset, link.align_fail} !== 17'h0) begin
      bad++; $display("FAIL midchk_async got=%h exp=00000", {link.data_out, link.data_valid, link.locked, link.offset, link.align_fail});
    end
    model_reset();
    @(negedge pixel_clk);
    reset_int = 1'b0;
    total++; if (link.offset !== 4'd0 || link.locked !== 1'b0) begin bad++; $display("FAIL midchk_release got=%0d/%b exp=0/0", link.offset, link.locked); end
    start_link(skew, 0);
    lock_up("midchk_relock", skew);
  endtask

  task automatic test_random();
    int skew;
    bit swap;
    for (int r = 0; r < 3; r++) begin
      skew = $urandom_range(0, 9);
      swap = 1'($urandom_range(0, 1));
      start_link(skew, swap);
      link.realign = 1; step(PAT); link.realign = 0;
      lock_up("random", skew);
      test_payload_random();
    end
  endtask

`ifdef RX_ALIGN_STATS_EN
  task automatic test_stats();
    total++; if (link.lock_loss_cnt !== 16'(m_loss)) begin bad++; $display("FAIL stats_loss got=%0d exp=%0d", link.lock_loss_cnt, m_loss); end
    total++; if (link.slip_total !== 16'(m_slips)) begin bad++; $display("FAIL stats_slip got=%0d exp=%0d", link.slip_total, m_slips); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge pixel_clk);
    test_reset();
    test_lock_plain();
    test_bitswap();
    test_payload_random();
    test_err_limit();
    test_realign();
`ifdef RX_ALIGN_STATS_EN
    test_stats();
`endif
    test_align_fail();
    test_reset_mid_check();
    test_random();
`ifdef RX_ALIGN_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
